xmt_arbiter: RTL and testbench



---
 rtl/xmt_arbiter_if.sv | 33 +++
 rtl/xmt_arbiter.sv | 160 ++++++++++++++++
 tb/tb_xmt_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xmt_arbiter_if.sv
// ============================================================================
// Module   : xmt_arbiter_if
// Brief    : Requester-side and transmitter-side signals of the xmt_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface xmt_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           xmt_load;
    logic [7:0]     xmt_data;
    logic           xmt_empty;
    logic           busy;
    logic [2:0]     cur_src;

    // Arbiter side
    modport master (
        input  req_valid, req_data, xmt_empty,
        output req_ack, xmt_load, xmt_data, busy, cur_src
    );

    // Requesters plus transmitter side
    modport slave (
        output req_valid, req_data, xmt_empty,
        input  req_ack, xmt_load, xmt_data, busy, cur_src
    );
endinterface

`default_nettype wire

// File: rtl/xmt_arbiter.sv
// ============================================================================
// Module   : xmt_arbiter
// Brief    : Round-robin sharing of one serial transmitter among N byte
//            streams, with optional source-tag insertion on source change.
// Revision : 1.0
// ============================================================================
`default_nettype none

module xmt_arbiter #(
    parameter int         N        = 4,
    parameter int         TAG_EN   = 1,
    parameter logic [7:0] TAG_BASE = 8'hF0
) (
    input  wire logic     clk,
    input  wire logic     reset,
    xmt_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_LOAD_TAG    = 3'd1,
        S_WAIT_BUSY_T = 3'd2,
        S_WAIT_DONE_T = 3'd3,
        S_LOAD_DATA   = 3'd4,
        S_WAIT_BUSY_D = 3'd5,
        S_WAIT_DONE_D = 3'd6
    } state_t;

    localparam logic [2:0] C_LAST_IDX = 3'(N - 1);

    state_t       r_state,      w_state_nxt;
    logic [N-1:0] r_req_ack,    w_req_ack_nxt;
    logic         r_xmt_load,   w_xmt_load_nxt;
    logic [7:0]   r_xmt_data,   w_xmt_data_nxt;
    logic         r_busy,       w_busy_nxt;
    logic [2:0]   r_cur_src,    w_cur_src_nxt;
    logic [2:0]   r_last_grant, w_last_grant_nxt;
    logic         r_tag_valid,  w_tag_valid_nxt;
    logic [7:0]   r_byte,       w_byte_nxt;

    logic         w_found;
    logic [2:0]   w_win;
    logic [7:0]   w_win_data;
    logic [N-1:0] w_win_ack;
    logic         w_need_tag;

    // Round-robin: first valid index above last_grant, otherwise wrap to the lowest.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int g = 0; g < N; g++) begin
            if (!w_found && bus.req_valid[g] && (3'(g) > r_last_grant)) begin
                w_found = 1'b1;
                w_win   = 3'(g);
            end
        end
        for (int g = 0; g < N; g++) begin
            if (!w_found && bus.req_valid[g] && (3'(g) <= r_last_grant)) begin
                w_found = 1'b1;
                w_win   = 3'(g);
            end
        end
        w_win_data = 8'h00;
        w_win_ack  = '0;
        for (int g = 0; g < N; g++) begin
            if (w_win == 3'(g)) begin
                w_win_data   = bus.req_data[g*8 +: 8];
                w_win_ack[g] = w_found;
            end
        end
        w_need_tag = (TAG_EN != 0) && (!r_tag_valid || (w_win != r_cur_src));
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_req_ack_nxt    = '0;
        w_xmt_load_nxt   = 1'b0;
        w_xmt_data_nxt   = r_xmt_data;
        w_busy_nxt       = r_busy;
        w_cur_src_nxt    = r_cur_src;
        w_last_grant_nxt = r_last_grant;
        w_tag_valid_nxt  = r_tag_valid;
        w_byte_nxt       = r_byte;
        case (r_state)
            S_IDLE: begin
                if (bus.xmt_empty && w_found) begin
                    w_req_ack_nxt    = w_win_ack;
                    w_last_grant_nxt = w_win;
                    w_cur_src_nxt    = w_win;
                    w_busy_nxt       = 1'b1;
                    w_byte_nxt       = w_win_data;
                    w_xmt_load_nxt   = 1'b1;
                    // Load strobe is registered alongside the state it belongs to.
                    if (w_need_tag) begin
                        w_state_nxt    = S_LOAD_TAG;
                        w_xmt_data_nxt = TAG_BASE + {5'b00000, w_win};
                    end else begin
                        w_state_nxt    = S_LOAD_DATA;
                        w_xmt_data_nxt = w_win_data;
                    end
                end
            end
            S_LOAD_TAG:    w_state_nxt = S_WAIT_BUSY_T;
            S_WAIT_BUSY_T: if (!bus.xmt_empty) w_state_nxt = S_WAIT_DONE_T;
            S_WAIT_DONE_T: begin
                if (bus.xmt_empty) begin
                    w_tag_valid_nxt = 1'b1;
                    w_state_nxt     = S_LOAD_DATA;
                    w_xmt_load_nxt  = 1'b1;
                    w_xmt_data_nxt  = r_byte;
                end
            end
            S_LOAD_DATA:   w_state_nxt = S_WAIT_BUSY_D;
            S_WAIT_BUSY_D: if (!bus.xmt_empty) w_state_nxt = S_WAIT_DONE_D;
            S_WAIT_DONE_D: begin
                if (bus.xmt_empty) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ack    <= '0;
            r_xmt_load   <= 1'b0;
            r_xmt_data   <= 8'h00;
            r_busy       <= 1'b0;
            r_cur_src    <= C_LAST_IDX;
            r_last_grant <= C_LAST_IDX;
            r_tag_valid  <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ack    <= w_req_ack_nxt;
            r_xmt_load   <= w_xmt_load_nxt;
            r_xmt_data   <= w_xmt_data_nxt;
            r_busy       <= w_busy_nxt;
            r_cur_src    <= w_cur_src_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_tag_valid  <= w_tag_valid_nxt;
            r_byte       <= w_byte_nxt;
        end
    end

    assign bus.req_ack  = r_req_ack;
    assign bus.xmt_load = r_xmt_load;
    assign bus.xmt_data = r_xmt_data;
    assign bus.busy     = r_busy;
    assign bus.cur_src  = r_cur_src;

endmodule

`default_nettype wire

// File: tb/tb_xmt_arbiter.sv
// ============================================================================
// Module   : tb_xmt_arbiter
// Brief    : Directed bench for xmt_arbiter with a transmitter stand-in.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xmt_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xmt_arbiter_if #(.N(N)) bus_a ();
    xmt_arbiter_if #(.N(N)) bus_b ();

    xmt_arbiter #(.N(N), .TAG_EN(1), .TAG_BASE(8'hF0)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
    xmt_arbiter #(.N(N), .TAG_EN(0), .TAG_BASE(8'hF0)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));

    logic [1:0] empty = 2'b11;
    assign bus_a.xmt_empty = empty[0];
    assign bus_b.xmt_empty = empty[1];

    logic [1:0] load_v;
    logic [7:0] data_v [2];
    assign load_v    = {bus_b.xmt_load, bus_a.xmt_load};
    assign data_v[0] = bus_a.xmt_data;
    assign data_v[1] = bus_b.xmt_data;

    logic [7:0] rqa [N][$];
    logic [7:0] rqb [N][$];
    logic [7:0] log_a [$];
    logic [7:0] log_b [$];
    int         ack_a [$];

    logic pend [2]     = '{1'b0, 1'b0};
    int   dly [2]      = '{0, 0};
    int   scnt [2]     = '{0, 0};
    logic hs_ok [2]    = '{1'b1, 1'b1};
    logic seen_low [2] = '{1'b0, 1'b0};
    int   viol [2]     = '{0, 0};
    int   extra_delay  = 0;
    logic busy_prev    = 1'b0;
    int   fall_loads   = 0;
    logic fall_empty   = 1'b0;

    int checks = 0;
    int errors = 0;

    // Transmitter stand-in, handshake monitor, load logger and requester feeders.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!empty[k]) seen_low[k] = 1'b1;
            else if (seen_low[k]) hs_ok[k] = 1'b1;
            if (load_v[k]) begin
                if (k == 0) log_a.push_back(data_v[k]);
                else        log_b.push_back(data_v[k]);
                if (!hs_ok[k]) viol[k]++;
                hs_ok[k]    = 1'b0;
                seen_low[k] = 1'b0;
                pend[k]     = 1'b1;
                dly[k]      = (k == 0) ? extra_delay : 0;
            end else if (pend[k]) begin
                if (dly[k] == 0) begin
                    empty[k] = 1'b0;
                    scnt[k]  = 20;
                    pend[k]  = 1'b0;
                end else begin
                    dly[k]--;
                end
            end else if (scnt[k] > 0) begin
                scnt[k]--;
                if (scnt[k] == 0) empty[k] = 1'b1;
            end
        end
        if (busy_prev && !bus_a.busy) begin
            fall_loads = log_a.size();
            fall_empty = empty[0];
        end
        busy_prev = bus_a.busy;
        for (int g = 0; g < N; g++) begin
            if (bus_a.req_ack[g] === 1'b1) begin
                ack_a.push_back(g);
                if (rqa[g].size() > 0) void'(rqa[g].pop_front());
            end
            if (bus_b.req_ack[g] === 1'b1) begin
                if (rqb[g].size() > 0) void'(rqb[g].pop_front());
            end
            bus_a.req_valid[g]        = (rqa[g].size() > 0);
            bus_a.req_data[g*8 +: 8]  = (rqa[g].size() > 0) ? rqa[g][0] : 8'hEE;
            bus_b.req_valid[g]        = (rqb[g].size() > 0);
            bus_b.req_data[g*8 +: 8]  = (rqb[g].size() > 0) ? rqb[g][0] : 8'hEE;
        end
    end

    function automatic bit all_quiet();
        bit q;
        q = !bus_a.busy && !bus_b.busy && (empty == 2'b11) && !pend[0] && !pend[1]
            && (scnt[0] == 0) && (scnt[1] == 0);
        for (int g = 0; g < N; g++) q = q && (rqa[g].size() == 0) && (rqb[g].size() == 0);
        return q;
    endfunction

    task automatic wait_idle(input string tag);
        int c = 0;
        while (!all_quiet() && c < 3000) begin
            @(negedge clk); #1;
            c++;
        end
        if (c >= 3000) begin
            checks++; errors++;
            $display("FAIL %s timeout waiting for idle", tag);
        end
    endtask

    task automatic do_reset();
        wait_idle("pre_reset");
        rst = 1'b1;
        @(negedge clk); #1;
        log_a.delete(); log_b.delete(); ack_a.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (bus_a.req_ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b exp 0000", bus_a.req_ack); end
        checks++; if (bus_a.xmt_load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", bus_a.xmt_load); end
        checks++; if (bus_a.xmt_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus_a.xmt_data); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus_a.busy); end
        checks++; if (bus_a.cur_src !== 3'd3) begin errors++; $display("FAIL reset_cur_src got %0d exp 3", bus_a.cur_src); end
        checks++; if (bus_b.cur_src !== 3'd3) begin errors++; $display("FAIL reset_cur_src_b got %0d exp 3", bus_b.cur_src); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got %b exp 0", bus_b.busy); end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_single_byte();
        logic [7:0] exp [2] = '{8'hF0, 8'h41};
        do_reset();
        rqa[0].push_back(8'h41);
        wait_idle("single");
        checks++; if (log_a.size() != 2) begin errors++; $display("FAIL single_count got %0d exp 2", log_a.size()); end
        for (int i = 0; i < 2 && i < log_a.size(); i++) begin
            checks++; if (log_a[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, log_a[i], exp[i]); end
        end
        checks++; if (ack_a.size() != 1 || ack_a[0] != 0) begin errors++; $display("FAIL single_ack got %0d acks exp one ack of 0", ack_a.size()); end
        checks++; if (fall_loads != 2 || fall_empty !== 1'b1) begin errors++; $display("FAIL single_busy_fall got loads=%0d empty=%b exp 2/1", fall_loads, fall_empty); end
        checks++; if (viol[0] != 0) begin errors++; $display("FAIL single_handshake got %0d exp 0", viol[0]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [10] = '{8'hF0, 8'h10, 8'hF1, 8'h11, 8'hF2, 8'h12, 8'hF3, 8'h13, 8'hF0, 8'h10};
        int         eg  [5]  = '{0, 1, 2, 3, 0};
        do_reset();
        rqa[0].push_back(8'h10); rqa[0].push_back(8'h10);
        rqa[1].push_back(8'h11); rqa[2].push_back(8'h12); rqa[3].push_back(8'h13);
        wait_idle("round_robin");
        checks++; if (log_a.size() != 10) begin errors++; $display("FAIL rr_count got %0d exp 10", log_a.size()); end
        for (int i = 0; i < 10 && i < log_a.size(); i++) begin
            checks++; if (log_a[i] !== exp[i]) begin errors++; $display("FAIL rr_byte%0d got %h exp %h", i, log_a[i], exp[i]); end
        end
        checks++; if (ack_a.size() != 5) begin errors++; $display("FAIL rr_acks got %0d exp 5", ack_a.size()); end
        for (int i = 0; i < 5 && i < ack_a.size(); i++) begin
            checks++; if (ack_a[i] != eg[i]) begin errors++; $display("FAIL rr_grant%0d got %0d exp %0d", i, ack_a[i], eg[i]); end
        end
    endtask

    task automatic test_same_source();
        logic [7:0] exp [4] = '{8'hF2, 8'hAA, 8'hBB, 8'hCC};
        do_reset();
        rqa[2].push_back(8'hAA); rqa[2].push_back(8'hBB); rqa[2].push_back(8'hCC);
        wait_idle("same_source");
        checks++; if (log_a.size() != 4) begin errors++; $display("FAIL stream_count got %0d exp 4", log_a.size()); end
        for (int i = 0; i < 4 && i < log_a.size(); i++) begin
            checks++; if (log_a[i] !== exp[i]) begin errors++; $display("FAIL stream_byte%0d got %h exp %h", i, log_a[i], exp[i]); end
        end
        checks++; if (bus_a.cur_src !== 3'd2) begin errors++; $display("FAIL stream_cur_src got %0d exp 2", bus_a.cur_src); end
        for (int i = 0; i < ack_a.size(); i++) begin
            checks++; if (ack_a[i] != 2) begin errors++; $display("FAIL stream_grant%0d got %0d exp 2", i, ack_a[i]); end
        end
    endtask

    task automatic test_no_tag();
        logic [7:0] exp [3] = '{8'h51, 8'h73, 8'h52};
        do_reset();
        rqb[1].push_back(8'h51); rqb[1].push_back(8'h52); rqb[3].push_back(8'h73);
        wait_idle("no_tag");
        checks++; if (log_b.size() != 3) begin errors++; $display("FAIL notag_count got %0d exp 3", log_b.size()); end
        for (int i = 0; i < 3 && i < log_b.size(); i++) begin
            checks++; if (log_b[i] !== exp[i]) begin errors++; $display("FAIL notag_byte%0d got %h exp %h", i, log_b[i], exp[i]); end
        end
        checks++; if (viol[1] != 0) begin errors++; $display("FAIL notag_handshake got %0d exp 0", viol[1]); end
    endtask

    task automatic test_handshake();
        int c = 0;
        int early = 0;
        do_reset();
        extra_delay = 5;
        rqa[0].push_back(8'h41);
        while (log_a.size() < 1 && c < 200) begin @(negedge clk); #1; c++; end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (log_a.size() > 1) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL hs_early_load got %0d exp 0", early); end
        wait_idle("handshake");
        extra_delay = 0;
        checks++; if (log_a.size() != 2) begin errors++; $display("FAIL hs_count got %0d exp 2", log_a.size()); end
        checks++; if (log_a.size() == 2 && log_a[1] !== 8'h41) begin errors++; $display("FAIL hs_data got %h exp 41", log_a[1]); end
        checks++; if (viol[0] != 0) begin errors++; $display("FAIL hs_violations got %0d exp 0", viol[0]); end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        rqa[0].push_back(8'h41);
        while (!(log_a.size() >= 2 && empty[0] == 1'b0) && c < 400) begin @(negedge clk); #1; c++; end
        repeat (3) begin @(negedge clk); #1; end
        checks++; if (bus_a.busy !== 1'b1 || bus_a.xmt_data !== 8'h41) begin errors++; $display("FAIL mid_pre got busy=%b data=%h exp 1/41", bus_a.busy, bus_a.xmt_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus_a.busy); end
        checks++; if (bus_a.xmt_data !== 8'h00) begin errors++; $display("FAIL mid_data got %h exp 00", bus_a.xmt_data); end
        checks++; if (bus_a.cur_src !== 3'd3) begin errors++; $display("FAIL mid_cur_src got %0d exp 3", bus_a.cur_src); end
        checks++; if (bus_a.req_ack !== 4'b0000 || bus_a.xmt_load !== 1'b0) begin errors++; $display("FAIL mid_ack_load got %b/%b exp 0000/0", bus_a.req_ack, bus_a.xmt_load); end
        @(negedge clk); #1;
        rst = 1'b0;
        log_a.delete(); ack_a.delete();
        rqa[0].push_back(8'h55);
        wait_idle("reset_mid");
        checks++; if (log_a.size() != 2) begin errors++; $display("FAIL mid_count got %0d exp 2", log_a.size()); end
        checks++; if (log_a.size() == 2 && (log_a[0] !== 8'hF0 || log_a[1] !== 8'h55)) begin errors++; $display("FAIL mid_seq got %h %h exp F0 55", log_a[0], log_a[1]); end
        checks++; if (ack_a.size() != 1) begin errors++; $display("FAIL mid_acks got %0d exp 1", ack_a.size()); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_same_source();
        test_no_tag();
        test_handshake();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
